quarter_wave_synth: RTL and testbench



---
 rtl/quarter_wave_synth_pkg.sv | 39 +++
 rtl/quarter_wave_synth_if.sv | 25 ++
 rtl/quarter_sine_rom.sv | 27 ++
 rtl/quarter_wave_synth.sv | 116 +++++++++++
 tb/tb_quarter_wave_synth.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/quarter_wave_synth_pkg.sv
// Shared constants for the quarter-wave sine synthesizer: default widths,
// ASK amplitude levels, the quarter-wave magnitude table and sign folding.
package sine_pkg;

  localparam int MAG_W_DEF  = 8;
  localparam int ADDR_W_DEF = 6;

  localparam logic [1:0] AMP_OFF  = 2'd0;
  localparam logic [1:0] AMP_QTR  = 2'd1;
  localparam logic [1:0] AMP_HALF = 2'd2;
  localparam logic [1:0] AMP_FULL = 2'd3;

  // q[i] = round(255 * sin(pi * i / 128)), first quadrant only
  localparam logic [MAG_W_DEF-1:0] QTAB [0:63] = '{
    8'd0,   8'd6,   8'd13,  8'd19,  8'd25,  8'd31,  8'd37,  8'd44,
    8'd50,  8'd56,  8'd62,  8'd68,  8'd74,  8'd80,  8'd86,  8'd92,
    8'd98,  8'd103, 8'd109, 8'd115, 8'd120, 8'd126, 8'd131, 8'd136,
    8'd142, 8'd147, 8'd152, 8'd157, 8'd162, 8'd167, 8'd171, 8'd176,
    8'd180, 8'd185, 8'd189, 8'd193, 8'd197, 8'd201, 8'd205, 8'd208,
    8'd212, 8'd215, 8'd219, 8'd222, 8'd225, 8'd228, 8'd231, 8'd233,
    8'd236, 8'd238, 8'd240, 8'd242, 8'd244, 8'd246, 8'd247, 8'd249,
    8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255
  };

  // Two's-complement negation of a zero-extended magnitude; -0 folds to 0
  function automatic logic [MAG_W_DEF:0] sign_fold(
    input logic [MAG_W_DEF-1:0] mag,
    input logic                 neg
  );
    logic [MAG_W_DEF:0] ext;
    ext = {1'b0, mag};
    if (neg) begin
      sign_fold = -ext;
    end else begin
      sign_fold = ext;
    end
  endfunction

endpackage

// File: rtl/quarter_wave_synth_if.sv
// Sample-request / sample-output bundle between the phase generator side
// and the quarter-wave synthesizer.
interface quarter_wave_synth_if #(
  parameter int MAG_W  = 8,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0]   cnt;
  logic                p;
  logic                s;
  logic [1:0]          amp;
  logic                in_valid;
  logic signed [MAG_W:0] sample;
  logic                out_valid;
  logic                zc;

  modport master (
    output cnt, p, s, amp, in_valid,
    input  sample, out_valid, zc
  );

  modport slave (
    input  cnt, p, s, amp, in_valid,
    output sample, out_valid, zc
  );
endinterface

// File: rtl/quarter_sine_rom.sv
// Registered-read quarter-wave magnitude ROM (lookup stage of the pipeline).
module quarter_sine_rom
  import sine_pkg::*;
#(
  parameter int MAG_W  = MAG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  logic [MAG_W-1:0] mag_r;

  // Registered table read
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_r <= '0;
    end else begin
      mag_r <= QTAB[addr];
    end
  end

  assign mag = mag_r;

endmodule

// File: rtl/quarter_wave_synth.sv
// Three-stage quarter-wave sine synthesizer: mirror addressing, table lookup,
// ASK scaling with sign folding, and zero-crossing flag on valid outputs.
module quarter_wave_synth
  import sine_pkg::*;
#(
  parameter int MAG_W  = MAG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  quarter_wave_synth_if.slave bus
);

  logic [ADDR_W-1:0]     addr_s;
  logic [ADDR_W-1:0]     addr_r;
  logic                  s1_s_r;
  logic [1:0]            s1_amp_r;
  logic                  s1_v_r;

  logic [MAG_W-1:0]      s2_mag_s;
  logic                  s2_s_r;
  logic [1:0]            s2_amp_r;
  logic                  s2_v_r;

  logic [MAG_W-1:0]      scaled_s;
  logic signed [MAG_W:0] shaped_s;
  logic signed [MAG_W:0] sample_r;
  logic                  out_valid_r;
  logic                  zc_r;
  logic                  last_s_r;

  // Mirror addressing: inversion maps cnt to (2^ADDR_W-1) - cnt
  always_comb begin
    addr_s = bus.cnt;
    if (bus.p) begin
      addr_s = ~bus.cnt;
    end else begin
      addr_s = bus.cnt;
    end
  end

  // Stage 1 registers: address and side-band captured together
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r   <= '0;
      s1_s_r   <= 1'b0;
      s1_amp_r <= AMP_OFF;
      s1_v_r   <= 1'b0;
    end else begin
      addr_r   <= addr_s;
      s1_s_r   <= bus.s;
      s1_amp_r <= bus.amp;
      s1_v_r   <= bus.in_valid;
    end
  end

  quarter_sine_rom #(
    .MAG_W  (MAG_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (addr_r),
    .mag  (s2_mag_s)
  );

  // Stage 2 registers: side-band travels alongside the ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_s_r   <= 1'b0;
      s2_amp_r <= AMP_OFF;
      s2_v_r   <= 1'b0;
    end else begin
      s2_s_r   <= s1_s_r;
      s2_amp_r <= s1_amp_r;
      s2_v_r   <= s1_v_r;
    end
  end

  // ASK scaling and sign folding of the looked-up magnitude
  always_comb begin
    scaled_s = '0;
    case (s2_amp_r)
      AMP_FULL: scaled_s = s2_mag_s;
      AMP_HALF: scaled_s = s2_mag_s >> 2'd1;
      AMP_QTR:  scaled_s = s2_mag_s >> 2'd2;
      AMP_OFF:  scaled_s = '0;
      default:  scaled_s = '0;
    endcase
    shaped_s = sign_fold(scaled_s, s2_s_r);
  end

  // Stage 3 registers: sample holds across bubbles, zc tracks valid outputs only
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r    <= '0;
      out_valid_r <= 1'b0;
      zc_r        <= 1'b0;
      last_s_r    <= 1'b0;
    end else begin
      out_valid_r <= s2_v_r;
      if (s2_v_r) begin
        sample_r <= shaped_s;
        zc_r     <= s2_s_r ^ last_s_r;
        last_s_r <= s2_s_r;
      end else begin
        zc_r     <= 1'b0;
      end
    end
  end

  assign bus.sample    = sample_r;
  assign bus.out_valid = out_valid_r;
  assign bus.zc        = zc_r;

endmodule

// File: tb/tb_quarter_wave_synth.sv
// Directed-vector bench for quarter_wave_synth: single-point vectors, bubble,
// two-period quadrant sweep and mid-stream reset, all against hand values.
module tb_quarter_wave_synth;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  quarter_wave_synth_if #(.MAG_W(8), .ADDR_W(6)) qi ();

  quarter_wave_synth #(.MAG_W(8), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (qi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] cnt;
    logic       p;
    logic       s;
    logic [1:0] amp;
    logic       v;
    int         e_smp;
    int         e_ov;
    int         e_zc;
  } vec_t;

  typedef enum logic [1:0] {QA, QB, QC, QD} quad_e;

  vec_t vt [12];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] c, input logic pp, input logic ss,
                       input logic [1:0] a, input logic v);
    qi.cnt      = c;
    qi.p        = pp;
    qi.s        = ss;
    qi.amp      = a;
    qi.in_valid = v;
  endtask

  initial begin
    quad_e      sw_q;
    logic [5:0] sw_cnt;
    int         prev_smp;
    int         smp;
    int         ph;
    int         c;
    int         qd;
    int         pk_max;
    int         pk_min;
    bit         mono;

    n_chk  = 0;
    n_fail = 0;

    vt[0]  = '{6'd32, 1'b0, 1'b0, 2'd3, 1'b1,  180, 1, 0};
    vt[1]  = '{6'd0,  1'b1, 1'b0, 2'd3, 1'b1,  255, 1, 0};
    vt[2]  = '{6'd63, 1'b1, 1'b1, 2'd3, 1'b1,    0, 1, 1};
    vt[3]  = '{6'd32, 1'b0, 1'b1, 2'd2, 1'b1,  -90, 1, 0};
    vt[4]  = '{6'd32, 1'b0, 1'b1, 2'd1, 1'b1,  -45, 1, 0};
    vt[5]  = '{6'd32, 1'b0, 1'b1, 2'd0, 1'b1,    0, 1, 0};
    vt[6]  = '{6'd16, 1'b0, 1'b0, 2'd3, 1'b1,   98, 1, 1};
    vt[7]  = '{6'd48, 1'b0, 1'b0, 2'd3, 1'b1,  236, 1, 0};
    vt[8]  = '{6'd5,  1'b0, 1'b1, 2'd3, 1'b0,  236, 0, 0};
    vt[9]  = '{6'd8,  1'b0, 1'b1, 2'd3, 1'b1,  -50, 1, 1};
    vt[10] = '{6'd63, 1'b0, 1'b0, 2'd1, 1'b1,   63, 1, 1};
    vt[11] = '{6'd62, 1'b1, 1'b1, 2'd2, 1'b1,   -3, 1, 1};

    rst = 1'b1;
    drive(6'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    tick();
    chk("rst_sample", int'(qi.sample), 0);
    chk("rst_ov", int'(qi.out_valid), 0);
    chk("rst_zc", int'(qi.zc), 0);
    rst = 1'b0;

    // Directed vectors: vector i driven at iteration i, observed at i+3
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i >= 3) begin
        chk($sformatf("vec%0d_smp", i - 3), int'(qi.sample), vt[i-3].e_smp);
        chk($sformatf("vec%0d_ov", i - 3), int'(qi.out_valid), vt[i-3].e_ov);
        chk($sformatf("vec%0d_zc", i - 3), int'(qi.zc), vt[i-3].e_zc);
      end else begin
        chk($sformatf("early_ov%0d", i), int'(qi.out_valid), 0);
      end
      if (i < 12) begin
        drive(vt[i].cnt, vt[i].p, vt[i].s, vt[i].amp, vt[i].v);
      end else begin
        drive(6'd0, 1'b0, 1'b0, 2'd3, 1'b0);
      end
    end

    // Two-period sweep from a free-running counter and quadrant FSM
    sw_q     = QA;
    sw_cnt   = 6'd0;
    prev_smp = 0;
    pk_max   = -1000;
    pk_min   = 1000;
    for (int t = 0; t < 515; t++) begin
      tick();
      if (t >= 3) begin
        ph  = (t - 3) % 256;
        c   = ph % 64;
        qd  = ph / 64;
        smp = int'(qi.sample);
        chk($sformatf("sw%0d_ov", t - 3), int'(qi.out_valid), 1);
        chk($sformatf("sw%0d_zc", t - 3), int'(qi.zc), (ph == 0 || ph == 128) ? 1 : 0);
        if (c != 0) begin
          mono = (qd == 0 || qd == 3) ? (smp >= prev_smp) : (smp <= prev_smp);
          chk($sformatf("sw%0d_mono", t - 3), int'(mono), 1);
        end
        if (ph == 0)   chk("swA0",  smp, 0);
        if (ph == 32)  chk("swA32", smp, 180);
        if (ph == 63)  chk("swA63", smp, 255);
        if (ph == 64)  chk("swB0",  smp, 255);
        if (ph == 96)  chk("swB32", smp, 176);
        if (ph == 127) chk("swB63", smp, 0);
        if (ph == 128) chk("swC0",  smp, 0);
        if (ph == 160) chk("swC32", smp, -180);
        if (ph == 191) chk("swC63", smp, -255);
        if (ph == 192) chk("swD0",  smp, -255);
        if (ph == 224) chk("swD32", smp, -176);
        if (ph == 255) chk("swD63", smp, 0);
        if (smp > pk_max) pk_max = smp;
        if (smp < pk_min) pk_min = smp;
        prev_smp = smp;
      end
      if (t < 512) begin
        drive(sw_cnt, (sw_q == QB || sw_q == QD), (sw_q == QC || sw_q == QD), 2'd3, 1'b1);
        if (sw_cnt == 6'd63) begin
          case (sw_q)
            QA:      sw_q = QB;
            QB:      sw_q = QC;
            QC:      sw_q = QD;
            QD:      sw_q = QA;
            default: sw_q = QA;
          endcase
        end
        sw_cnt = sw_cnt + 6'd1;
      end else begin
        drive(6'd0, 1'b0, 1'b0, 2'd3, 1'b0);
      end
    end
    chk("peak_pos", pk_max, 255);
    chk("peak_neg", pk_min, -255);

    // Mid-stream reset with a continuous negative-half stream
    drive(6'd32, 1'b0, 1'b1, 2'd3, 1'b1);
    repeat (5) tick();
    chk("pre_rst_smp", int'(qi.sample), -180);
    chk("pre_rst_zc", int'(qi.zc), 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_smp", int'(qi.sample), 0);
    chk("mid_rst_ov", int'(qi.out_valid), 0);
    chk("mid_rst_zc", int'(qi.zc), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ov1", int'(qi.out_valid), 0);
    tick();
    chk("post_rst_ov2", int'(qi.out_valid), 0);
    tick();
    chk("post_rst_ov3", int'(qi.out_valid), 1);
    chk("post_rst_zc3", int'(qi.zc), 1);
    chk("post_rst_smp3", int'(qi.sample), -180);
    tick();
    chk("post_rst_zc4", int'(qi.zc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
